// File: rtl/snn_aer_pkg.sv
// Shared types and constants for the SNN AER transmit path.
package snn_aer_pkg;

  typedef enum logic [2:0] {IDLE, LATCH, REQ_HI, ACK_LO} aer_tx_state_t;

  // Word the ROC encoder emits during its reset sequence; forwarded unchanged.
  localparam logic [9:0] AER_RST_WORD = 10'h1FF;

endpackage

// File: rtl/sync_ff.sv
// Generic single-bit synchroniser: STAGES flops, asynchronous clear to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] vld_pipe;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-2:0], D};
  end

  assign Q = vld_pipe[STAGES-1];

endmodule

// File: rtl/aer_event_tx.sv
// Delivers encoder indices to the SNN core over a 4-phase AER REQ/ACK handshake,
// with per-phase timeout and a saturating delivered-event counter.
module aer_event_tx
  import snn_aer_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_BITS    = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [ADDR_BITS-1:0] NEXT_INDEX,
  input  logic                 FOUND_NEXT_INDEX,
  output logic                 AERIN_CTRL_BUSY,
  output logic [ADDR_BITS-1:0] AERIN_ADDR,
  output logic                 AERIN_REQ,
  input  logic                 AERIN_ACK,
  output logic                 TIMEOUT_ERR,
  output logic [CNT_BITS-1:0]  EVENT_CNT
);

  localparam int                TMR_BITS = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_BITS-1:0] TMR_MAX = TMR_BITS'(TIMEOUT_CYC - 1);

  aer_tx_state_t       state_q, state_d;
  logic [TMR_BITS-1:0] timer_q;
  logic                ack_s;
  logic                addr_ld, req_set, req_clr, cnt_inc, tmo, tmr_last;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (AERIN_ACK),
    .Q   (ack_s)
  );

  assign tmr_last = (timer_q == TMR_MAX);

  always_comb begin
    state_d = state_q;
    addr_ld = 1'b0;
    req_set = 1'b0;
    req_clr = 1'b0;
    cnt_inc = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: if (FOUND_NEXT_INDEX) begin
        addr_ld = 1'b1;
        state_d = LATCH;
      end
      // Encoder's index is only valid on its last strobe cycle, so keep reloading.
      LATCH: if (FOUND_NEXT_INDEX) begin
        addr_ld = 1'b1;
      end else begin
        req_set = 1'b1;
        state_d = REQ_HI;
      end
      REQ_HI: if (ack_s) begin
        req_clr = 1'b1;
        state_d = ACK_LO;
      end else if (tmr_last) begin
        tmo     = 1'b1;
        req_clr = 1'b1;
        state_d = IDLE;
      end
      ACK_LO: if (!ack_s) begin
        cnt_inc = 1'b1;
        state_d = IDLE;
      end else if (tmr_last) begin
        tmo     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      AERIN_ADDR      <= '0;
      AERIN_REQ       <= 1'b0;
      AERIN_CTRL_BUSY <= 1'b0;
      TIMEOUT_ERR     <= 1'b0;
      EVENT_CNT       <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)                      timer_q <= '0;
      else if (state_q == REQ_HI || state_q == ACK_LO) timer_q <= timer_q + 1'b1;
      if (addr_ld) AERIN_ADDR <= NEXT_INDEX;
      if (req_set)      AERIN_REQ <= 1'b1;
      else if (req_clr) AERIN_REQ <= 1'b0;
      // Rises with the move out of IDLE, falls one cycle after IDLE is re-entered.
      AERIN_CTRL_BUSY <= (state_q != IDLE) || (state_d != IDLE);
      if (tmo) TIMEOUT_ERR <= 1'b1;
      if (cnt_inc && !(&EVENT_CNT)) EVENT_CNT <= EVENT_CNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_aer_event_tx.sv
// Directed bench for aer_event_tx: encoder strobe model, delayed ACK responder,
// timeout, async reset and counter saturation scenarios.
module tb_aer_event_tx;
  import snn_aer_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] NEXT_INDEX = '0;
  logic       FOUND_NEXT_INDEX = 1'b0;
  logic       AERIN_ACK;

  logic        busy1, req1, err1, busy2, req2, err2;
  logic [9:0]  addr1, addr2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  int  tests = 0;
  int  fails = 0;
  bit  ack_en = 1'b0;
  int  ack_dly;
  logic       req_prev = 1'b0;
  logic [9:0] sent_q[$];

  always #5 CLK = ~CLK;

  aer_event_tx #(.TIMEOUT_CYC(16), .CNT_BITS(16)) u_dut1 (
    .CLK(CLK), .RST(RST), .NEXT_INDEX(NEXT_INDEX), .FOUND_NEXT_INDEX(FOUND_NEXT_INDEX),
    .AERIN_CTRL_BUSY(busy1), .AERIN_ADDR(addr1), .AERIN_REQ(req1), .AERIN_ACK(AERIN_ACK),
    .TIMEOUT_ERR(err1), .EVENT_CNT(cnt1)
  );

  aer_event_tx #(.TIMEOUT_CYC(16), .CNT_BITS(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .NEXT_INDEX(NEXT_INDEX), .FOUND_NEXT_INDEX(FOUND_NEXT_INDEX),
    .AERIN_CTRL_BUSY(busy2), .AERIN_ADDR(addr2), .AERIN_REQ(req2), .AERIN_ACK(AERIN_ACK),
    .TIMEOUT_ERR(err2), .EVENT_CNT(cnt2)
  );

  // Core-side responder: ACK follows REQ after 3 cycles in each direction.
  initial begin
    AERIN_ACK = 1'b0;
    ack_dly   = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (!ack_en) ack_dly = 0;
      else if (req1 != AERIN_ACK) begin
        ack_dly++;
        if (ack_dly >= 3) begin
          AERIN_ACK = req1;
          ack_dly   = 0;
        end
      end else ack_dly = 0;
    end
  end

  // Record the address presented on every REQ rise.
  always @(negedge CLK) begin
    if (req1 && !req_prev) sent_q.push_back(addr1);
    req_prev <= req1;
  end

  // The encoder must never strobe while a handshake is in flight.
  always @(posedge CLK) begin
    if (!RST && FOUND_NEXT_INDEX && (u_dut1.state_q == REQ_HI || u_dut1.state_q == ACK_LO)) begin
      fails++;
      $display("FAIL protocol: strobe during handshake at %0t", $time);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    RST = 1'b1; FOUND_NEXT_INDEX = 1'b0; NEXT_INDEX = '0;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy1 && n < bound) begin @(negedge CLK); n++; end
    if (busy1) begin
      tests++; fails++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles", busy1, bound);
    end
  endtask

  task automatic strobe(input logic [9:0] a, input logic [9:0] b);
    FOUND_NEXT_INDEX = 1'b1; NEXT_INDEX = a;
    @(negedge CLK);
    NEXT_INDEX = b;
    @(negedge CLK);
    FOUND_NEXT_INDEX = 1'b0; NEXT_INDEX = '0;
  endtask

  task automatic send_event(input logic [9:0] a, input logic [9:0] b);
    wait_idle(200);
    strobe(a, b);
    wait_idle(200);
  endtask

  task automatic test_reset;
    do_reset();
    tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", busy1); end
    tests++; if (addr1 !== 10'h000) begin fails++; $display("FAIL rst_addr: got %h want 000", addr1); end
    tests++; if (req1 !== 1'b0) begin fails++; $display("FAIL rst_req: got %0b want 0", req1); end
    tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL rst_err: got %0b want 0", err1); end
    tests++; if (cnt1 !== 16'd0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", cnt1); end
    tests++; if ({busy2, req2, err2, addr2, cnt2} !== 15'd0) begin
      fails++; $display("FAIL rst_dut2: got %h want 0", {busy2, req2, err2, addr2, cnt2});
    end
  endtask

  task automatic test_two_cycle_strobe;
    int n;
    do_reset();
    ack_en = 1'b1;
    FOUND_NEXT_INDEX = 1'b1; NEXT_INDEX = 10'h000;
    @(negedge CLK);
    tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL strobe_busy: got %0b want 1", busy1); end
    NEXT_INDEX = 10'h02A;
    @(negedge CLK);
    FOUND_NEXT_INDEX = 1'b0; NEXT_INDEX = '0;
    tests++; if (req1 !== 1'b0) begin fails++; $display("FAIL strobe_req_early: got %0b want 0", req1); end
    @(negedge CLK);
    tests++; if (req1 !== 1'b1 || addr1 !== 10'h02A) begin
      fails++; $display("FAIL strobe_req: req %0b addr %h want 1 02a", req1, addr1);
    end
    n = 0;
    while (AERIN_ACK !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    while (AERIN_ACK !== 1'b0 && n < 100) begin @(negedge CLK); n++; end
    n = 0;
    while (busy1 && n < 20) begin @(negedge CLK); n++; end
    tests++; if (n !== 4) begin fails++; $display("FAIL busy_fall_latency: got %0d want 4", n); end
    tests++; if (cnt1 !== 16'd1) begin fails++; $display("FAIL strobe_cnt: got %0d want 1", cnt1); end
  endtask

  task automatic test_reset_pair;
    do_reset();
    sent_q.delete();
    ack_en = 1'b1;
    send_event(AER_RST_WORD, AER_RST_WORD);
    send_event(AER_RST_WORD, AER_RST_WORD);
    tests++; if (sent_q.size() !== 2) begin fails++; $display("FAIL pair_size: got %0d want 2", sent_q.size()); end
    foreach (sent_q[k]) begin
      tests++; if (sent_q[k] !== 10'h1FF) begin fails++; $display("FAIL pair_addr%0d: got %h want 1ff", k, sent_q[k]); end
    end
    tests++; if (cnt1 !== 16'd2) begin fails++; $display("FAIL pair_cnt: got %0d want 2", cnt1); end
  endtask

  task automatic test_saturation;
    do_reset();
    ack_en = 1'b1;
    for (int i = 0; i < 5; i++) send_event(10'h000, 10'(i + 1));
    tests++; if (cnt2 !== 2'd3) begin fails++; $display("FAIL sat_cnt2: got %0d want 3", cnt2); end
    tests++; if (cnt1 !== 16'd5) begin fails++; $display("FAIL sat_cnt1: got %0d want 5", cnt1); end
  endtask

  task automatic test_full_image;
    logic [9:0] exp;
    do_reset();
    sent_q.delete();
    ack_en = 1'b1;
    send_event(AER_RST_WORD, AER_RST_WORD);
    send_event(AER_RST_WORD, AER_RST_WORD);
    for (int i = 255; i >= 0; i--) send_event(10'h155, 10'(i));
    tests++; if (sent_q.size() !== 258) begin fails++; $display("FAIL image_size: got %0d want 258", sent_q.size()); end
    foreach (sent_q[k]) begin
      exp = (k < 2) ? 10'h1FF : 10'(257 - k);
      tests++; if (sent_q[k] !== exp) begin fails++; $display("FAIL image_addr%0d: got %h want %h", k, sent_q[k], exp); end
    end
    tests++; if (cnt1 !== 16'd258) begin fails++; $display("FAIL image_cnt: got %0d want 258", cnt1); end
    tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL image_err: got %0b want 0", err1); end
    tests++; if (cnt2 !== 2'd3) begin fails++; $display("FAIL image_cnt2: got %0d want 3", cnt2); end
  endtask

  task automatic test_timeout;
    int n;
    do_reset();
    ack_en = 1'b0;
    strobe(10'h000, 10'h0AB);
    @(negedge CLK);
    tests++; if (req1 !== 1'b1) begin fails++; $display("FAIL tmo_req_rise: got %0b want 1", req1); end
    n = 0;
    while (req1 && n < 100) begin @(negedge CLK); n++; end
    tests++; if (n !== 16) begin fails++; $display("FAIL tmo_req_cycles: got %0d want 16", n); end
    tests++; if (err1 !== 1'b1) begin fails++; $display("FAIL tmo_err: got %0b want 1", err1); end
    tests++; if (cnt1 !== 16'd0) begin fails++; $display("FAIL tmo_cnt: got %0d want 0", cnt1); end
    @(negedge CLK);
    tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL tmo_busy: got %0b want 0", busy1); end
    ack_en = 1'b1;
    send_event(10'h000, 10'h03C);
    tests++; if (err1 !== 1'b1 || cnt1 !== 16'd1) begin
      fails++; $display("FAIL tmo_sticky: err %0b cnt %0d want 1 1", err1, cnt1);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    ack_en = 1'b1;
    send_event(10'h000, 10'h011);
    ack_en = 1'b0;
    strobe(10'h000, 10'h022);
    @(negedge CLK);
    tests++; if (req1 !== 1'b1) begin fails++; $display("FAIL arst_pre_req: got %0b want 1", req1); end
    #2 RST = 1'b1;
    #1;
    tests++; if (req1 !== 1'b0 || busy1 !== 1'b0 || addr1 !== 10'h000 || cnt1 !== 16'd0) begin
      fails++; $display("FAIL arst_outputs: req %0b busy %0b addr %h cnt %0d want 0", req1, busy1, addr1, cnt1);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    ack_en = 1'b1;
    sent_q.delete();
    send_event(10'h000, 10'h033);
    tests++; if (cnt1 !== 16'd1 || sent_q.size() !== 1) begin
      fails++; $display("FAIL arst_resume_cnt: cnt %0d sent %0d want 1 1", cnt1, sent_q.size());
    end else begin
      tests++; if (sent_q[0] !== 10'h033) begin fails++; $display("FAIL arst_resume_addr: got %h want 033", sent_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_two_cycle_strobe();
    test_reset_pair();
    test_saturation();
    test_full_image();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
